// File: rtl/dds_freq_meter.sv
// dds_freq_meter: counts rising edges of a tone over a fixed window and scales to NCO increment units
module dds_freq_meter #(
    parameter int ACC_WIDTH       = 8,
    parameter int PHASE_INC_WIDTH = 8,
    parameter int WIN_LOG2        = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       sig_in,
    output logic                       busy,
    output logic                       done,
    output logic [WIN_LOG2:0]          edge_count,
    output logic [PHASE_INC_WIDTH-1:0] inc_est,
    output logic                       saturated,
    output logic                       timeout
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;
    localparam int SHIFT = ACC_WIDTH - WIN_LOG2;
    localparam logic [WIN_LOG2:0] WIN_LEN = (WIN_LOG2+1)'(1) << WIN_LOG2;
    localparam logic [ACC_WIDTH:0] INC_MAX = (ACC_WIDTH+1)'({PHASE_INC_WIDTH{1'b1}});

    logic [1:0]          state;
    logic                prev;
    logic                rise;
    logic                sat;
    logic [WIN_LOG2:0]   win_cnt;
    logic [WIN_LOG2:0]   edge_cnt;
    logic [WIN_LOG2:0]   edge_next;
    logic [ACC_WIDTH:0]  raw;

    // edge detect, running count including this cycle's edge, and its scaled/saturated value
    always_comb begin
        rise      = sig_in & ~prev;
        edge_next = edge_cnt + {{WIN_LOG2{1'b0}}, rise};
        raw       = (ACC_WIDTH+1)'(edge_next) << SHIFT;
        sat       = raw > INC_MAX;
        busy      = (state == ARM) || (state == MEASURE);
        done      = state == DONE;
    end

    // measurement FSM; win_cnt counts ARM cycles while waiting, then window cycles 1..WIN_LEN
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= 1'b0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            edge_count <= '0;
            inc_est    <= '0;
            saturated  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            prev <= sig_in;
            case (state)
                IDLE: if (start) begin
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                    state    <= ARM;
                end
                ARM: if (rise) begin
                    win_cnt <= (WIN_LOG2+1)'(1);
                    state   <= MEASURE;
                end else if (win_cnt == WIN_LEN - 1'b1) begin
                    edge_count <= '0;
                    inc_est    <= '0;
                    saturated  <= 1'b0;
                    timeout    <= 1'b1;
                    state      <= DONE;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                end
                MEASURE: begin
                    edge_cnt <= edge_next;
                    if (win_cnt == WIN_LEN) begin
                        edge_count <= edge_next;
                        inc_est    <= sat ? '1 : raw[PHASE_INC_WIDTH-1:0];
                        saturated  <= sat;
                        timeout    <= 1'b0;
                        state      <= DONE;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_freq_meter.sv
// tb_dds_freq_meter: directed checks of dds_freq_meter driven by an 8-bit NCO model
module tb_dds_freq_meter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       sig_in = 1'b0;
    logic       busy, done, saturated, timeout;
    logic [6:0] edge_count;
    logic [7:0] inc_est;
    logic       busy6, done6, sat6, to6;
    logic [6:0] ec6;
    logic [5:0] inc6;

    logic [7:0] acc = 8'd0;
    logic [7:0] inc = 8'd0;
    logic       sig_prev = 1'b0;
    logic       rise_at = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         m_lat, m_done, m_edges;

    always #5 clk = ~clk;

    dds_freq_meter dut (
        .clk(clk), .reset(reset), .start(start), .sig_in(sig_in),
        .busy(busy), .done(done), .edge_count(edge_count), .inc_est(inc_est),
        .saturated(saturated), .timeout(timeout)
    );

    dds_freq_meter #(.PHASE_INC_WIDTH(6)) dut6 (
        .clk(clk), .reset(reset), .start(start), .sig_in(sig_in),
        .busy(busy6), .done(done6), .edge_count(ec6), .inc_est(inc6),
        .saturated(sat6), .timeout(to6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock: note the edge the DUT sees, then advance the NCO
    task automatic tick;
        @(posedge clk);
        rise_at  = sig_in && !sig_prev;
        sig_prev = sig_in;
        cyc++;
        #1;
        acc    = acc + inc;
        sig_in = acc[7];
    endtask

    // one run: optional stray start at align+poke, optional reset at align+rst_at
    task automatic measure(input int poke, input int rst_at);
        int s, align;
        start = 1'b1;
        tick;
        start = 1'b0;
        s = cyc;
        align = -1;
        m_lat = -1;
        m_done = 0;
        m_edges = 0;
        for (int i = 0; i < 250; i++) begin
            tick;
            if (start) start = 1'b0;
            if (align < 0 && rise_at) align = cyc;
            else if (align >= 0 && cyc <= align + 64 && rise_at) m_edges++;
            if (done) begin
                m_done++;
                if (m_lat < 0) m_lat = cyc + 1 - (align < 0 ? s : align);
                check("busy_at_done", busy, 0);
            end
            if (align >= 0 && poke > 0 && cyc == align + poke) start = 1'b1;
            if (align >= 0 && rst_at > 0 && cyc == align + rst_at) begin
                reset = 1'b1;
                tick;
                reset = 1'b0;
                check("rst_clear", {busy, done, edge_count, inc_est, saturated, timeout}, 0);
                check("rst_clear6", {busy6, done6, ec6, inc6, sat6, to6}, 0);
            end
        end
    endtask

    initial begin
        repeat (3) tick;
        check("reset_state", {busy, done, edge_count, inc_est, saturated, timeout}, 0);
        reset = 1'b0;
        tick;

        inc = 8'd16;
        measure(0, 0);
        check("s1_edges", edge_count, 4);
        check("s1_inc", inc_est, 16);
        check("s1_sat", saturated, 0);
        check("s1_timeout", timeout, 0);
        check("s1_latency", m_lat, 65);
        check("s1_ndone", m_done, 1);
        check("s1_model", edge_count, m_edges);
        check("s1_inc6", inc6, 16);

        inc = 8'd128;
        measure(0, 0);
        check("s2_edges", edge_count, 32);
        check("s2_inc", inc_est, 128);
        check("s2_sat", saturated, 0);
        check("s2_inc6", inc6, 63);
        check("s2_sat6", sat6, 1);

        inc = 8'd0;
        acc = 8'd0;
        sig_in = 1'b0;
        measure(0, 0);
        check("s3_timeout", timeout, 1);
        check("s3_edges", edge_count, 0);
        check("s3_inc", inc_est, 0);
        check("s3_latency", m_lat, 65);
        check("s3_ndone", m_done, 1);

        inc = 8'd16;
        measure(10, 0);
        check("s4_ndone", m_done, 1);
        check("s4_edges", edge_count, 4);
        check("s4_inc", inc_est, 16);
        check("s4_timeout", timeout, 0);
        check("s4_latency", m_lat, 65);
        check("s4_idle", busy, 0);

        measure(0, 30);
        check("s5_no_done", m_done, 0);
        measure(0, 0);
        check("s5_edges", edge_count, 4);
        check("s5_inc", inc_est, 16);
        check("s5_latency", m_lat, 65);

        inc = 8'd37;
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 20)) tick;
            measure(0, 0);
            check("s6_model", edge_count, m_edges);
            check("s6_range", (edge_count >= 9 && edge_count <= 10), 1);
            check("s6_inc", inc_est, m_edges * 4);
            check("s6_ndone", m_done, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
